// File: rtl/drum_voice_sched.sv
//------------------------------------------------------------------------------
// drum_voice_sched
//
// Purpose:
//   Shares one synchronous single-port sample ROM among NUM_VOICES one-shot
//   drum voices. On every sample-rate tick it walks all voice slots in fixed
//   order. Each slot takes two cycles (ADDR, DATA) whether or not the voice is
//   playing. It sums the signed samples of the active voices, saturates the
//   sum to DATA_W bits and presents it in offset-binary form.
//
// Parameters:
//   NUM_VOICES  number of voice slots (2..8)
//   ADDR_W      sample ROM address width
//   DATA_W      sample width (ROM holds signed two's-complement samples)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   tick          one-cycle sample-rate strobe (ignored while busy)
//   trig          per-voice start pulse (restarts at offset 0)
//   voice_base    voice i start address at [i*ADDR_W +: ADDR_W]
//   voice_len     voice i length in samples at [i*ADDR_W +: ADDR_W], 0 = off
//   rom_rd        ROM read strobe
//   rom_addr      ROM address
//   rom_data      ROM read data, valid one cycle after rom_rd
//   sample_out    mixed sample, offset binary (silence = 0x80 for 8 bits)
//   sample_valid  one-cycle pulse when sample_out updates
//   active        per-voice playing flag
//   busy          scan in progress
//   overrun       (only with DRUM_SCHED_OVERRUN_EN) sticky: tick seen while
//                 busy; cleared by rst only
//
// Optional feature macro: DRUM_SCHED_OVERRUN_EN
//------------------------------------------------------------------------------
module drum_voice_sched #(
    parameter int NUM_VOICES = 4,
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         tick,
    input  logic [NUM_VOICES-1:0]        trig,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_base,
    input  logic [NUM_VOICES*ADDR_W-1:0] voice_len,
    output logic                         rom_rd,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic [DATA_W-1:0]            sample_out,
    output logic                         sample_valid,
    output logic [NUM_VOICES-1:0]        active,
    output logic                         busy
`ifdef DRUM_SCHED_OVERRUN_EN
    ,
    output logic                         overrun
`endif
);

    localparam int SW = $clog2(NUM_VOICES);
    localparam int AW = DATA_W + $clog2(NUM_VOICES) + 1;

    localparam logic signed [AW-1:0] SMAX = AW'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [AW-1:0] SMIN = AW'(-(2 ** (DATA_W - 1)));

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t                  state;
    logic [SW-1:0]           slot;
    logic [ADDR_W-1:0]       offset [NUM_VOICES];
    logic [NUM_VOICES-1:0]   pending;
    logic signed [AW-1:0]    acc;

    // Combinational helpers
    logic [NUM_VOICES-1:0]   trig_ok;
    logic [SW-1:0]           nslot;
    logic [ADDR_W-1:0]       cur_len;
    logic [ADDR_W-1:0]       cur_off1;
    logic [ADDR_W-1:0]       nxt_base;
    logic [ADDR_W-1:0]       base0;
    logic signed [AW-1:0]    ext;
    logic [DATA_W-1:0]       sat;

    // Triggers on zero-length voices are dropped at the source, so they
    // never reach pending or active.
    always_comb begin
        trig_ok = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            trig_ok[i] = trig[i] & (|voice_len[i*ADDR_W +: ADDR_W]);
        end
    end

    always_comb begin
        nslot    = (int'(slot) == NUM_VOICES - 1) ? '0 : slot + 1'b1;
        cur_len  = voice_len[int'(slot) * ADDR_W +: ADDR_W];
        cur_off1 = offset[slot] + 1'b1;
        nxt_base = voice_base[int'(nslot) * ADDR_W +: ADDR_W];
        base0    = voice_base[ADDR_W-1:0];
        ext      = {{(AW - DATA_W){rom_data[DATA_W-1]}}, rom_data};
    end

    always_comb begin
        if (acc > SMAX) begin
            sat = SMAX[DATA_W-1:0];
        end else if (acc < SMIN) begin
            sat = SMIN[DATA_W-1:0];
        end else begin
            sat = acc[DATA_W-1:0];
        end
    end

    // The ROM read for a slot is issued on the edge that enters ADDR, so
    // rom_rd is high during the ADDR cycle and the data lands during DATA.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            slot         <= '0;
            acc          <= '0;
            pending      <= '0;
            active       <= '0;
            busy         <= 1'b0;
            rom_rd       <= 1'b0;
            rom_addr     <= '0;
            sample_out   <= {1'b1, {(DATA_W - 1){1'b0}}};
            sample_valid <= 1'b0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                offset[i] <= '0;
            end
`ifdef DRUM_SCHED_OVERRUN_EN
            overrun      <= 1'b0;
`endif
        end else begin
            rom_rd       <= 1'b0;
            sample_valid <= 1'b0;

`ifdef DRUM_SCHED_OVERRUN_EN
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
`endif

            case (state)
                IDLE: begin
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (trig_ok[i]) begin
                            active[i] <= 1'b1;
                            offset[i] <= '0;
                        end
                    end
                    if (tick) begin
                        acc   <= '0;
                        slot  <= '0;
                        busy  <= 1'b1;
                        state <= ADDR;
                        // Slot 0 sees a same-cycle trigger as already applied.
                        if (trig_ok[0]) begin
                            rom_rd   <= 1'b1;
                            rom_addr <= base0;
                        end else if (active[0]) begin
                            rom_rd   <= 1'b1;
                            rom_addr <= base0 + offset[0];
                        end
                    end
                end

                ADDR: begin
                    pending <= pending | trig_ok;
                    state   <= DATA;
                end

                DATA: begin
                    pending <= pending | trig_ok;
                    if (active[slot]) begin
                        acc <= acc + ext;
                        if (cur_off1 == cur_len) begin
                            active[slot] <= 1'b0;
                            offset[slot] <= '0;
                        end else begin
                            offset[slot] <= cur_off1;
                        end
                    end
                    if (int'(slot) == NUM_VOICES - 1) begin
                        state <= DONE;
                    end else begin
                        slot  <= nslot;
                        state <= ADDR;
                        if (active[nslot]) begin
                            rom_rd   <= 1'b1;
                            rom_addr <= nxt_base + offset[nslot];
                        end
                    end
                end

                DONE: begin
                    sample_out   <= {~sat[DATA_W-1], sat[DATA_W-2:0]};
                    sample_valid <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                    // Triggers arriving in this very cycle are applied too.
                    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                        if (pending[i] || trig_ok[i]) begin
                            active[i] <= 1'b1;
                            offset[i] <= '0;
                        end
                    end
                    pending <= '0;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
